slurm32_cpu_regfile: RTL and testbench
======================================

Name: slurm32_cpu_regfile

Overview:
- Register file at the receiving end of the writeback stage.
- Takes the stage-4 write select/data pair from the writeback stage and commits it to a 256 x 32 register array.
- Serves two registered read ports to the decode/register-read stage, with write-to-read bypass, a pipeline hold, and r0 hard-wired to zero.
- Array has no reset, so a post-reset clear sequencer zeroes every entry before the pipeline is released.

Parameters:
- REG_BITS, 8, width of register select; array depth = 2^REG_BITS.
- DATA_BITS, 32, register width.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- reg_wr_sel  input  REG_BITS  writeback destination from writeback stage; 0 = no write.
- reg_in  input  DATA_BITS  writeback data paired with reg_wr_sel.
- rd_sel_a  input  REG_BITS  read port A select from decode.
- rd_sel_b  input  REG_BITS  read port B select from decode.
- hold  input  1  pipeline stall; freezes read selects.
- reg_a_out  output  DATA_BITS  registered read data, port A.
- reg_b_out  output  DATA_BITS  registered read data, port B.
- ready  output  1  high once clear sequence is complete; pipeline must not issue before this.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- States: CLEAR, RUN.
- Reset values (edge with RST=1): state=CLEAR, clr_idx=0, ready=0, reg_a_out=0, reg_b_out=0, latched selects=0.
- CLEAR:
  - Each edge writes mem[clr_idx]=0 and increments clr_idx.
  - The edge that clears entry 255 sets state=RUN and ready=1, so ready rises on the 256th edge after RST deasserts.
  - reg_wr_sel writes are dropped; read outputs are held at 0; read selects are ignored.
- RST asserted at any time, including mid-CLEAR: returns to CLEAR with clr_idx=0 and ready=0; the clear restarts from entry 0.
- Write (RUN): if reg_wr_sel != 0, mem[reg_wr_sel] <= reg_in at the edge. Writes commit regardless of hold. Writes to r0 are discarded.
- Read (RUN, hold=0):
  - At the edge, lat_sel_x <= rd_sel_x.
  - reg_x_out <= 0 if rd_sel_x==0.
  - Otherwise reg_x_out <= reg_in if reg_wr_sel==rd_sel_x (same-cycle bypass).
  - Otherwise reg_x_out <= mem[rd_sel_x].
  - Read latency is 1 cycle.
- Read (RUN, hold=1):
  - Selects stay latched and rd_sel_x is ignored.
  - reg_x_out holds its value, except that if reg_wr_sel != 0 and reg_wr_sel == lat_sel_x, reg_x_out <= reg_in at that edge.
  - Result: a stalled consumer never sees stale data.
- Both ports may select the same register; both ports may bypass the same write in the same cycle.
- Arithmetic: clr_idx is REG_BITS wide and may wrap to 0 after 255; the state change prevents reuse.
- No combinational path from inputs to outputs.

Test Plan:
- Clear sequence: RST=1 for 2 cycles, then 0 -> ready=0 for 255 edges and 1 on the 256th edge; reg_a_out=reg_b_out=0 throughout CLEAR. Then read r7 -> 32'h00000000.
- Write/read: reg_wr_sel=8'h03, reg_in=32'haa55aa55 for one cycle; then rd_sel_a=8'h03 -> reg_a_out=32'haa55aa55 one cycle later.
- Bypass: same cycle drive reg_wr_sel=8'h05, reg_in=32'hdeadbeef, rd_sel_a=rd_sel_b=8'h05 -> both outputs 32'hdeadbeef after 1 edge.
- r0: reg_wr_sel=0, reg_in=32'hffffffff, rd_sel_a=0 -> reg_a_out=0. Write 8'h00 via data, then read r0 again -> still 0.
- Hold tracking:
  - Latch rd_sel_a=8'h04 holding 32'h11111111, then assert hold and change rd_sel_a=8'h09 -> reg_a_out stays 32'h11111111.
  - During hold write r4=32'h22222222 -> reg_a_out=32'h22222222 next edge.
  - Release hold -> reg_a_out=mem[9].
- Reset mid-clear and write drop: assert RST 100 cycles into CLEAR -> ready stays 0 for a full 256 further edges. During CLEAR, reg_wr_sel=8'h0a, reg_in=32'h12345678 -> after ready, reading r10 returns 0.

Source files
------------

// File: rtl/slurm32_cpu_regfile.sv
// Writeback-side register file: 2^REG_BITS x DATA_BITS array, two registered read ports
// with write bypass and hold tracking, r0 reads zero, and a post-reset clear sequencer.
module slurm32_cpu_regfile #(
  parameter int REG_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [REG_BITS-1:0]  reg_wr_sel,
  input  logic [DATA_BITS-1:0] reg_in,
  input  logic [REG_BITS-1:0]  rd_sel_a,
  input  logic [REG_BITS-1:0]  rd_sel_b,
  input  logic                 hold,
  output logic [DATA_BITS-1:0] reg_a_out,
  output logic [DATA_BITS-1:0] reg_b_out,
  output logic                 ready
);

  // state | meaning
  // CLEAR | zeroing one array entry per edge; writes dropped, outputs held at 0
  // RUN   | normal operation, ready=1
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [REG_BITS-1:0] IDX_ONE  = {{(REG_BITS-1){1'b0}}, 1'b1};
  localparam logic [REG_BITS-1:0] IDX_LAST = {REG_BITS{1'b1}};
  localparam logic [REG_BITS-1:0] SEL_ZERO = '0;

  state_t                state_q, state_d;
  logic [REG_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic                  ready_q, ready_d;
  logic [DATA_BITS-1:0]  reg_a_q, reg_a_d;
  logic [DATA_BITS-1:0]  reg_b_q, reg_b_d;
  logic [REG_BITS-1:0]   lat_a_q, lat_a_d;
  logic [REG_BITS-1:0]   lat_b_q, lat_b_d;

  logic [DATA_BITS-1:0]  mem [2**REG_BITS];
  logic                  mem_we;
  logic [REG_BITS-1:0]   mem_waddr;
  logic [DATA_BITS-1:0]  mem_wdata;

  logic                  wr_valid;
  logic [DATA_BITS-1:0]  rd_a_data, rd_b_data;

  assign wr_valid = (reg_wr_sel != SEL_ZERO);

  // Read path sees the pre-edge array; a same-cycle write is forwarded from reg_in.
  always_comb begin
    rd_a_data = mem[rd_sel_a];
    if (rd_sel_a == SEL_ZERO)        rd_a_data = '0;
    else if (reg_wr_sel == rd_sel_a) rd_a_data = reg_in;
  end

  always_comb begin
    rd_b_data = mem[rd_sel_b];
    if (rd_sel_b == SEL_ZERO)        rd_b_data = '0;
    else if (reg_wr_sel == rd_sel_b) rd_b_data = reg_in;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    lat_a_d   = lat_a_q;
    lat_b_d   = lat_b_q;
    mem_we    = 1'b0;
    mem_waddr = reg_wr_sel;
    mem_wdata = reg_in;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + IDX_ONE;
        reg_a_d   = '0;
        reg_b_d   = '0;
        if (clr_idx_q == IDX_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        mem_we = wr_valid;
        if (!hold) begin
          lat_a_d = rd_sel_a;
          lat_b_d = rd_sel_b;
          reg_a_d = rd_a_data;
          reg_b_d = rd_b_data;
        end else begin
          // Stalled consumer keeps tracking writes to the register it latched.
          if (wr_valid && reg_wr_sel == lat_a_q) reg_a_d = reg_in;
          if (wr_valid && reg_wr_sel == lat_b_q) reg_b_d = reg_in;
        end
      end
      default: state_d = CLEAR;
    endcase

    if (RST) mem_we = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      lat_a_q   <= '0;
      lat_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      lat_a_q   <= lat_a_d;
      lat_b_q   <= lat_b_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign reg_a_out = reg_a_q;
  assign reg_b_out = reg_b_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_slurm32_cpu_regfile.sv
// Bench for slurm32_cpu_regfile: directed scenarios plus randomized traffic, all outputs
// compared every cycle against an array-based reference model.
module tb_slurm32_cpu_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  reg_wr_sel;
  logic [31:0] reg_in;
  logic [7:0]  rd_sel_a;
  logic [7:0]  rd_sel_b;
  logic        hold;
  logic [31:0] reg_a_out;
  logic [31:0] reg_b_out;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_mem [256];
  logic        m_run;
  int          m_cnt;
  logic [31:0] m_a, m_b;
  logic [7:0]  m_lat_a, m_lat_b;

  slurm32_cpu_regfile #(.REG_BITS(8), .DATA_BITS(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .reg_wr_sel(reg_wr_sel),
    .reg_in    (reg_in),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .hold      (hold),
    .reg_a_out (reg_a_out),
    .reg_b_out (reg_b_out),
    .ready     (ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] sel);
    if (sel == 8'd0)        return 32'd0;
    if (sel == reg_wr_sel)  return reg_in;
    return m_mem[sel];
  endfunction

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge CLK);
    #1;
    if (RST) begin
      m_run = 1'b0; m_cnt = 0; m_a = '0; m_b = '0; m_lat_a = '0; m_lat_b = '0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == 256) begin
        m_run = 1'b1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      if (!hold) begin
        m_lat_a = rd_sel_a;
        m_lat_b = rd_sel_b;
        m_a = model_read(rd_sel_a);
        m_b = model_read(rd_sel_b);
      end else begin
        if (reg_wr_sel != 8'd0 && reg_wr_sel == m_lat_a) m_a = reg_in;
        if (reg_wr_sel != 8'd0 && reg_wr_sel == m_lat_b) m_b = reg_in;
      end
      if (reg_wr_sel != 8'd0) m_mem[reg_wr_sel] = reg_in;
    end
    chk("ready", {31'd0, ready}, {31'd0, m_run});
    chk("reg_a", reg_a_out, m_a);
    chk("reg_b", reg_b_out, m_b);
  endtask

  task automatic drive(input logic [7:0] wsel, input logic [31:0] wdat,
                       input logic [7:0] sa, input logic [7:0] sb, input logic h);
    reg_wr_sel = wsel; reg_in = wdat; rd_sel_a = sa; rd_sel_b = sb; hold = h;
  endtask

  initial begin
    int ready_early;
    RST = 1'b1;
    drive(8'd0, 32'd0, 8'd0, 8'd0, 1'b0);
    m_run = 1'b0; m_cnt = 0; m_a = '0; m_b = '0; m_lat_a = '0; m_lat_b = '0;
    foreach (m_mem[i]) m_mem[i] = '0;

    step(); step();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_a", reg_a_out, 32'd0);

    // clear sequence with a write that must be dropped and noisy read selects
    RST = 1'b0;
    ready_early = 0;
    for (int i = 0; i < 255; i++) begin
      drive(8'h0a, 32'h12345678, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
      step();
      if (ready) ready_early++;
    end
    chk("clr_ready_early", 32'(ready_early), 32'd0);
    step();
    chk("clr_ready_256", {31'd0, ready}, 32'd1);

    drive(8'd0, 32'd0, 8'h07, 8'h0a, 1'b0);
    step();
    chk("r7_zero", reg_a_out, 32'd0);
    chk("r10_dropped", reg_b_out, 32'd0);

    // write then read
    drive(8'h03, 32'haa55aa55, 8'd0, 8'd0, 1'b0); step();
    drive(8'd0, 32'd0, 8'h03, 8'd0, 1'b0);        step();
    chk("wr_rd_r3", reg_a_out, 32'haa55aa55);

    // bypass on both ports
    drive(8'h05, 32'hdeadbeef, 8'h05, 8'h05, 1'b0); step();
    chk("byp_a", reg_a_out, 32'hdeadbeef);
    chk("byp_b", reg_b_out, 32'hdeadbeef);

    // r0
    drive(8'd0, 32'hffffffff, 8'd0, 8'd0, 1'b0); step();
    chk("r0_a", reg_a_out, 32'd0);
    drive(8'd0, 32'd0, 8'd0, 8'd0, 1'b0); step();
    chk("r0_again", reg_a_out, 32'd0);

    // hold tracking
    drive(8'h04, 32'h11111111, 8'd0, 8'd0, 1'b0); step();
    drive(8'h09, 32'h33333333, 8'h04, 8'd0, 1'b0); step();
    chk("hold_latch", reg_a_out, 32'h11111111);
    drive(8'd0, 32'd0, 8'h09, 8'd0, 1'b1); step();
    chk("hold_keep", reg_a_out, 32'h11111111);
    drive(8'h04, 32'h22222222, 8'h09, 8'd0, 1'b1); step();
    chk("hold_track", reg_a_out, 32'h22222222);
    drive(8'd0, 32'd0, 8'h09, 8'd0, 1'b0); step();
    chk("hold_release", reg_a_out, 32'h33333333);

    // randomized traffic on a narrow register window to force collisions
    for (int i = 0; i < 3000; i++) begin
      drive(8'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 15)),
            8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      step();
    end

    // reset mid-clear, with writes offered throughout
    drive(8'h0a, 32'h12345678, 8'h0a, 8'h0a, 1'b0);
    RST = 1'b1; step();
    RST = 1'b0;
    for (int i = 0; i < 100; i++) step();
    RST = 1'b1; step();
    RST = 1'b0;
    ready_early = 0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (ready) ready_early++;
    end
    chk("reclr_ready_early", 32'(ready_early), 32'd0);
    step();
    chk("reclr_ready_256", {31'd0, ready}, 32'd1);
    drive(8'd0, 32'd0, 8'h0a, 8'h03, 1'b0); step();
    chk("reclr_r10", reg_a_out, 32'd0);
    chk("reclr_r3", reg_b_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
